// File: rtl/pipe_skid_latch_pkg.sv
// Shared types and defaults for the pipeline skid latch.
package cpu_types_pkg;

    localparam int unsigned DEF_WIDTH = 256;
    localparam int unsigned DEF_CNTW  = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    // Number of entries held for a given state.
    function automatic logic [1:0] occ_of(input pipe_state_t s);
        case (s)
            ONE:     occ_of = 2'd1;
            FULL:    occ_of = 2'd2;
            default: occ_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_skid_latch_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter
    import cpu_types_pkg::*;
#(
    parameter int unsigned CNTW = DEF_CNTW
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            inc,
    input  logic            clr,
    output logic [CNTW-1:0] count
);

    // Count up on inc, stick at all-ones, clear on clr.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_skid_latch.sv
// Two-entry pipeline latch (main + skid) with registered handshake
// outputs and a stall-cycle counter.
module pipe_skid_latch
    import cpu_types_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNTW  = DEF_CNTW
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy,
    output logic [CNTW-1:0]  stall_cnt,
    input  logic             clr_cnt
);

    pipe_state_t      state;
    pipe_state_t      state_nxt;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_nxt;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_nxt;
    logic             accept;
    logic             emit;

    // in_ready/out_valid are flops, so out_ready never reaches in_ready.
    assign accept   = in_valid & in_ready;
    assign emit     = out_valid & out_ready;
    assign out_data = main_q;

    // Next-state and payload steering; flush overrides everything.
    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (flush) begin
            state_nxt = EMPTY;
            main_nxt  = '0;
            skid_nxt  = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt = ONE;
                        main_nxt  = in_data;
                    end
                end
                ONE: begin
                    case ({accept, emit})
                        2'b10: begin
                            state_nxt = FULL;
                            skid_nxt  = in_data;
                        end
                        2'b01: begin
                            state_nxt = EMPTY;
                            main_nxt  = '0;
                        end
                        2'b11: begin
                            main_nxt  = in_data;
                        end
                        default: ;
                    endcase
                end
                FULL: begin
                    if (emit) begin
                        state_nxt = ONE;
                        main_nxt  = skid_q;
                        skid_nxt  = '0;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                    main_nxt  = '0;
                    skid_nxt  = '0;
                end
            endcase
        end
    end

    // State, payload and handshake outputs, all decoded from next state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            state     <= state_nxt;
            main_q    <= main_nxt;
            skid_q    <= skid_nxt;
            in_ready  <= (state_nxt != FULL);
            out_valid <= (state_nxt != EMPTY);
            occupancy <= occ_of(state_nxt);
        end
    end

    sat_counter #(
        .CNTW(CNTW)
    ) u_stall_cnt (
        .CLK  (CLK),
        .RST  (RST),
        .inc  (out_valid & ~out_ready),
        .clr  (clr_cnt),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_latch.sv
// Directed bench for pipe_skid_latch with WIDTH=32, CNTW=4.
module tb_pipe_skid_latch;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNTW  = 4;

    logic             CLK;
    logic             RST;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [1:0]       occupancy;
    logic [CNTW-1:0]  stall_cnt;
    logic             clr_cnt;

    int unsigned n_tests;
    int unsigned n_fail;

    pipe_skid_latch #(
        .WIDTH(WIDTH),
        .CNTW (CNTW)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt),
        .clr_cnt  (clr_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [1:0] occ,
                                input logic [WIDTH-1:0] data);
        check({tag, ".occ"},   64'(occupancy), 64'(occ));
        check({tag, ".oval"},  64'(out_valid), 64'(occ != 2'd0));
        check({tag, ".irdy"},  64'(in_ready),  64'(occ != 2'd2));
        check({tag, ".odata"}, 64'(out_data),  64'(data));
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        RST       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        clr_cnt   = 1'b0;
        #12;
        expect_state("reset", 2'd0, 32'h0);
        check("reset.stall", 64'(stall_cnt), 64'd0);
        RST = 1'b0;
        tick();

        // Streaming: one entry per cycle, head visible one cycle later.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h1;
        tick();
        expect_state("stream1", 2'd1, 32'h1);
        in_data = 32'h2;
        tick();
        expect_state("stream2", 2'd1, 32'h2);
        in_data = 32'h3;
        tick();
        expect_state("stream3", 2'd1, 32'h3);
        in_valid = 1'b0;
        tick();
        expect_state("stream_drain", 2'd0, 32'h0);
        check("stream.stall", 64'(stall_cnt), 64'd0);

        // Backpressure: fill to FULL, 0xC must wait for space.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        tick();
        expect_state("bp_a", 2'd1, 32'hA);
        in_data = 32'hB;
        tick();
        expect_state("bp_full", 2'd2, 32'hA);
        check("bp.stall1", 64'(stall_cnt), 64'd1);
        in_data = 32'hC;
        tick();
        expect_state("bp_hold", 2'd2, 32'hA);
        check("bp.stall2", 64'(stall_cnt), 64'd2);
        out_ready = 1'b1;
        tick();
        expect_state("bp_b", 2'd1, 32'hB);
        tick();
        expect_state("bp_c", 2'd1, 32'hC);
        in_valid = 1'b0;
        tick();
        expect_state("bp_empty", 2'd0, 32'h0);
        check("bp.stall_keep", 64'(stall_cnt), 64'd2);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("clr", 64'(stall_cnt), 64'd0);

        // Flush while FULL with a competing accept.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        expect_state("fl_full", 2'd2, 32'hA);
        flush   = 1'b1;
        in_data = 32'hC;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        expect_state("fl_empty", 2'd0, 32'h0);
        check("fl.stall", 64'(stall_cnt), 64'd2);
        out_ready = 1'b1;
        tick();
        expect_state("fl_noc", 2'd0, 32'h0);

        // Saturation of the stall counter.
        clr_cnt = 1'b1;
        tick();
        clr_cnt   = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h7;
        tick();
        in_valid = 1'b0;
        check("sat.start", 64'(stall_cnt), 64'd0);
        for (int i = 0; i < 20; i++) tick();
        check("sat.15", 64'(stall_cnt), 64'd15);
        expect_state("sat_hold", 2'd1, 32'h7);
        clr_cnt = 1'b1;
        tick();
        check("sat.clr", 64'(stall_cnt), 64'd0);
        clr_cnt = 1'b0;
        tick();
        check("sat.restart", 64'(stall_cnt), 64'd1);

        // Async reset between edges while FULL.
        in_valid = 1'b1;
        in_data  = 32'hB;
        tick();
        expect_state("ar_full", 2'd2, 32'h7);
        #2;
        RST = 1'b1;
        #1;
        expect_state("ar_reset", 2'd0, 32'h0);
        check("ar.stall", 64'(stall_cnt), 64'd0);
        #1;
        RST      = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h5;
        tick();
        expect_state("ar_first", 2'd1, 32'h5);
        in_valid = 1'b0;
        tick();
        expect_state("ar_hold", 2'd1, 32'h5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
